mem_access: RTL and testbench

Memory-access pipeline stage placed directly after the second execute stage. It takes the execute result as an effective address plus the store data, the memory control bits and the register-write control. It runs one byte/halfword/word transaction on the data-memory request/acknowledge bus, stalling the pipeline until the memory acknowledges. It registers the aligned, extended load data and the forwarded execute result into the MEM/WB pipeline register for write-back.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/mem_access_if.sv | 23 ++
 rtl/load_align.sv | 44 ++++
 rtl/mem_access.sv | 185 ++++++++++++++++++
 tb/tb_mem_access.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the memory-access stage.
//   memfunc_t  - access type encoding (bit 2 = unsigned for loads)
//   state_t    - bus FSM states
//   misaligned - 1 when an access of the given type cannot be issued at addr[1:0]
package mem_pkg;

  typedef enum logic [2:0] {
    MF_B  = 3'b000,
    MF_H  = 3'b001,
    MF_W  = 3'b010,
    MF_BU = 3'b100,
    MF_HU = 3'b101
  } memfunc_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Size is carried by memfunc[1:0]: 00 byte, 01 half, 1x word (covers the
  // reserved codes, which behave as word). Bit 2 never affects alignment.
  function automatic logic misaligned(input logic [2:0] memfunc,
                                      input logic [1:0] addr);
    logic r;
    if (memfunc[1])      r = (addr != 2'b00);
    else if (memfunc[0]) r = addr[0];
    else                 r = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: data-memory request/acknowledge bus.
//   MemReq/MemWe/MemAddr/MemBE/MemWData : master -> memory
//   MemRData/MemAck                      : memory -> master
// MemRData is only meaningful in the cycle MemAck is high.
interface mem_access_if;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [3:0]  MemBE;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
  logic        MemAck;

  modport master (
    output MemReq, MemWe, MemAddr, MemBE, MemWData,
    input  MemRData, MemAck
  );

  modport slave (
    input  MemReq, MemWe, MemAddr, MemBE, MemWData,
    output MemRData, MemAck
  );
endinterface

// File: rtl/load_align.sv
// load_align: picks the addressed byte/half lane out of a little-endian
// 32-bit read word and sign- or zero-extends it to 32 bits.
//   i_rdata   in  32  raw word from memory
//   i_addr    in  2   byte offset of the access
//   i_memfunc in  3   access type (mem_pkg::memfunc_t encoding)
//   o_data    out 32  aligned, extended load value
// Purely combinational so the writeback forwarding path can share it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_memfunc,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  // Only aligned halves reach here, so addr[1] alone picks the lane.
  assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = i_rdata;
    case (i_memfunc)
      MF_B:    o_data = {{24{w_byte[7]}}, w_byte};
      MF_BU:   o_data = {24'h0, w_byte};
      MF_H:    o_data = {{16{w_half[15]}}, w_half};
      MF_HU:   o_data = {16'h0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage after the second execute stage.
//   Clock, nReset                  clock and async active-low reset
//   RegWriteIn/MemReadIn/
//   MemWriteIn/MemtoRegIn          control from execute
//   MemfuncIn [2:0]                access type
//   AddrIn [31:0]                  effective address / ALU result
//   RtDataIn [31:0]                store data
//   RAddrIn [4:0]                  destination register
//   bus (master)                   data-memory req/ack bus, all outputs registered
//   Stall                          combinational upstream hold
//   AddrErr                        one-cycle misalignment pulse
//   RegWriteOut/MemtoRegOut/
//   RAddrOut/ALUDataOut/MemDataOut MEM/WB pipeline register
module mem_access
  import mem_pkg::*;
(
  input  logic        Clock,
  input  logic        nReset,
  input  logic        RegWriteIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic        MemtoRegIn,
  input  logic [2:0]  MemfuncIn,
  input  logic [31:0] AddrIn,
  input  logic [31:0] RtDataIn,
  input  logic [4:0]  RAddrIn,
  mem_access_if.master bus,
  output logic        Stall,
  output logic        AddrErr,
  output logic        RegWriteOut,
  output logic        MemtoRegOut,
  output logic [4:0]  RAddrOut,
  output logic [31:0] ALUDataOut,
  output logic [31:0] MemDataOut
);

  state_t      r_state, w_next;

  logic        w_memop, w_mis, w_start;
  logic        w_stall, w_launch, w_done;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ld;

  logic        r_req, r_we;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;
  logic        r_addr_err;
  logic        r_regwrite, r_memtoreg;
  logic [4:0]  r_raddr;
  logic [31:0] r_alu, r_memdata;

  // A simultaneous read+write request is a write; only the write flag
  // reaches the bus, so no extra priority logic is needed.
  assign w_memop = MemReadIn | MemWriteIn;
  assign w_mis   = w_memop & misaligned(MemfuncIn, AddrIn[1:0]);
  assign w_start = w_memop & ~w_mis;

  // ---------------- FSM ----------------
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_stall  = 1'b0;
    w_launch = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_stall  = 1'b1;
          w_launch = 1'b1;
          w_next   = BUSY;
        end
      end
      BUSY: begin
        // Ack only means something here; elsewhere it is never looked at.
        if (bus.MemAck) begin
          w_done = 1'b1;
          w_next = IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign Stall = w_stall;

  // ---------------- store shaping ----------------
  // Data is replicated into every lane so the memory only has to honour BE.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = RtDataIn;
    case (MemfuncIn[1:0])
      2'b00: begin
        w_be    = 4'b0001 << AddrIn[1:0];
        w_wdata = {4{RtDataIn[7:0]}};
      end
      2'b01: begin
        w_be    = AddrIn[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{RtDataIn[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = RtDataIn;
      end
    endcase
  end

  // ---------------- bus registers ----------------
  // Async reset clears MemReq immediately, abandoning any open transaction.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
    end else if (w_launch) begin
      r_req   <= 1'b1;
      r_we    <= MemWriteIn;
      r_addr  <= {AddrIn[31:2], 2'b00};
      r_be    <= w_be;
      r_wdata <= w_wdata;
    end else if (w_done) begin
      r_req   <= 1'b0;
    end
  end

  assign bus.MemReq   = r_req;
  assign bus.MemWe    = r_we;
  assign bus.MemAddr  = r_addr;
  assign bus.MemBE    = r_be;
  assign bus.MemWData = r_wdata;

  // Misaligned ops never leave IDLE, so the pulse lasts exactly one cycle.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) r_addr_err <= 1'b0;
    else         r_addr_err <= (r_state == IDLE) & w_mis;
  end

  assign AddrErr = r_addr_err;

  // ---------------- load alignment ----------------
  // Upstream holds AddrIn/MemfuncIn while stalled, so they still describe
  // the access in the ack cycle.
  load_align u_load_align (
    .i_rdata   (bus.MemRData),
    .i_addr    (AddrIn[1:0]),
    .i_memfunc (MemfuncIn),
    .o_data    (w_ld)
  );

  // ---------------- MEM/WB register ----------------
  // Stalled cycles insert a bubble: write controls drop, data fields hold.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_raddr    <= '0;
      r_alu      <= '0;
      r_memdata  <= '0;
    end else if (!w_stall) begin
      r_regwrite <= RegWriteIn & ~w_mis;
      r_memtoreg <= MemtoRegIn;
      r_raddr    <= RAddrIn;
      r_alu      <= AddrIn;
      if (w_done && !r_we) r_memdata <= w_ld;
    end else begin
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
    end
  end

  assign RegWriteOut = r_regwrite;
  assign MemtoRegOut = r_memtoreg;
  assign RAddrOut    = r_raddr;
  assign ALUDataOut  = r_alu;
  assign MemDataOut  = r_memdata;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: scoreboard bench for mem_access. A driver issues ops and
// pushes expected bus and MEM/WB results; a memory responder checks requests
// and acks after a per-op delay; a monitor pops and compares MEM/WB results.
module tb_mem_access;

  logic        Clock = 1'b0;
  logic        nReset;
  logic        RegWriteIn, MemReadIn, MemWriteIn, MemtoRegIn;
  logic [2:0]  MemfuncIn;
  logic [31:0] AddrIn, RtDataIn;
  logic [4:0]  RAddrIn;
  logic        Stall, AddrErr, RegWriteOut, MemtoRegOut;
  logic [4:0]  RAddrOut;
  logic [31:0] ALUDataOut, MemDataOut;

  mem_access_if bus();

  mem_access dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .RegWriteIn  (RegWriteIn),
    .MemReadIn   (MemReadIn),
    .MemWriteIn  (MemWriteIn),
    .MemtoRegIn  (MemtoRegIn),
    .MemfuncIn   (MemfuncIn),
    .AddrIn      (AddrIn),
    .RtDataIn    (RtDataIn),
    .RAddrIn     (RAddrIn),
    .bus         (bus),
    .Stall       (Stall),
    .AddrErr     (AddrErr),
    .RegWriteOut (RegWriteOut),
    .MemtoRegOut (MemtoRegOut),
    .RAddrOut    (RAddrOut),
    .ALUDataOut  (ALUDataOut),
    .MemDataOut  (MemDataOut)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          wait_n;
    logic [31:0] rdata;
  } bus_exp_t;

  typedef struct {
    logic        rw, m2r, aerr;
    logic [4:0]  ra;
    logic [31:0] alu, mdata;
  } wb_exp_t;

  bus_exp_t    bus_q[$];
  wb_exp_t     sb_q[$];
  int          errs = 0;
  int          chks = 0;
  logic        op_valid = 1'b0;
  logic [31:0] exp_mdata = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [2:0] mf);
    if (mf[1]) return 4;
    if (mf[0]) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] mf, input logic [1:0] a,
                                             input logic [31:0] rdata);
    logic [31:0] sh;
    int sz;
    sz = op_size(mf);
    sh = rdata >> (8 * int'(a));
    if (sz == 4) return rdata;
    if (sz == 2) return mf[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
    return mf[2] ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] mf, input logic [31:0] rt);
    int sz;
    sz = op_size(mf);
    if (sz == 1) return {4{rt[7:0]}};
    if (sz == 2) return {2{rt[15:0]}};
    return rt;
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input logic rd, input logic wr, input logic rw, input logic m2r,
                        input logic [2:0] mf, input logic [31:0] addr, input logic [31:0] rt,
                        input logic [4:0] ra, input int wait_n, input logic [31:0] rdata);
    int       sz, stalls;
    bit       fired, mis, memop;
    bus_exp_t b;
    wb_exp_t  w;
    logic [3:0] be_full;
    @(posedge Clock); #1;
    RegWriteIn = rw; MemReadIn = rd; MemWriteIn = wr; MemtoRegIn = m2r;
    MemfuncIn = mf; AddrIn = addr; RtDataIn = rt; RAddrIn = ra;
    op_valid = 1'b1;
    sz    = op_size(mf);
    memop = rd | wr;
    mis   = memop && ((int'(addr[1:0]) % sz) != 0);
    if (memop && !mis) begin
      be_full  = 4'((1 << sz) - 1);
      b.we     = wr;
      b.addr   = {addr[31:2], 2'b00};
      b.be     = be_full << addr[1:0];
      b.wdata  = store_data(mf, rt);
      b.wait_n = wait_n;
      b.rdata  = rdata;
      bus_q.push_back(b);
    end
    stalls = 0;
    fired  = 0;
    for (int c = 0; c < 64 && !fired; c++) begin
      @(negedge Clock); #1;
      if (Stall === 1'b0) fired = 1;
      else stalls++;
    end
    if (!fired) begin
      errs++; chks++;
      $display("FAIL stall_timeout: Stall still high after 64 cycles, addr %h", addr);
      $display("Result: errors=%0d of %0d checks", errs, chks);
      $fatal(1, "stall timeout");
    end
    chk("stall_cycles", 32'(stalls), 32'((memop && !mis) ? 1 + wait_n : 0));
    if (rd && !wr && !mis) exp_mdata = load_value(mf, addr[1:0], rdata);
    w.rw    = rw && !(memop && mis);
    w.m2r   = m2r;
    w.aerr  = memop && mis;
    w.ra    = ra;
    w.alu   = addr;
    w.mdata = exp_mdata;
    sb_q.push_back(w);
  endtask

  task automatic clear_inputs();
    RegWriteIn = 0; MemReadIn = 0; MemWriteIn = 0; MemtoRegIn = 0;
    MemfuncIn = 0; AddrIn = 0; RtDataIn = 0; RAddrIn = 0;
    op_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_MemReq"},      32'(bus.MemReq),   32'h0);
    chk({tag, "_MemWe"},       32'(bus.MemWe),    32'h0);
    chk({tag, "_MemAddr"},     bus.MemAddr,       32'h0);
    chk({tag, "_MemBE"},       32'(bus.MemBE),    32'h0);
    chk({tag, "_MemWData"},    bus.MemWData,      32'h0);
    chk({tag, "_AddrErr"},     32'(AddrErr),      32'h0);
    chk({tag, "_RegWriteOut"}, 32'(RegWriteOut),  32'h0);
    chk({tag, "_MemtoRegOut"}, 32'(MemtoRegOut),  32'h0);
    chk({tag, "_RAddrOut"},    32'(RAddrOut),     32'h0);
    chk({tag, "_ALUDataOut"},  ALUDataOut,        32'h0);
    chk({tag, "_MemDataOut"},  MemDataOut,        32'h0);
  endtask

  // ---------------- memory responder ----------------
  bus_exp_t cur;
  bit       in_txn = 0;
  int       cnt = 0;

  always @(negedge Clock) begin
    if (!nReset) begin
      in_txn = 0;
      bus.MemAck = 1'b0;
    end else if (bus.MemAck) begin
      // Ack was seen at the last edge: request must drop for at least a cycle.
      bus.MemAck = 1'b0;
      in_txn = 0;
      chk("req_gap", 32'(bus.MemReq), 32'h0);
    end else if (bus.MemReq) begin
      if (!in_txn) begin
        chks++;
        if (bus_q.size() == 0) begin
          errs++;
          $display("FAIL unexpected_req: MemReq=1 addr %h with no request expected", bus.MemAddr);
          cur.we = bus.MemWe; cur.addr = bus.MemAddr; cur.be = bus.MemBE;
          cur.wdata = bus.MemWData; cur.wait_n = 0; cur.rdata = 32'h0;
        end else begin
          cur = bus_q.pop_front();
        end
        in_txn = 1;
        cnt = 0;
      end
      chk("MemWe",    32'(bus.MemWe), 32'(cur.we));
      chk("MemAddr",  bus.MemAddr,    cur.addr);
      chk("MemBE",    32'(bus.MemBE), 32'(cur.be));
      if (cur.we) chk("MemWData", bus.MemWData, cur.wdata);
      if (cnt == cur.wait_n) begin
        bus.MemAck   = 1'b1;
        bus.MemRData = cur.rdata;
      end else begin
        bus.MemRData = $urandom;
      end
      cnt++;
    end
  end

  // ---------------- monitor ----------------
  bit pending = 0;
  bit prev_stall = 0;

  always @(negedge Clock) begin
    wb_exp_t e;
    #1;
    if (!nReset) begin
      pending = 0;
      prev_stall = 0;
    end else begin
      if (pending) begin
        chks++;
        if (sb_q.size() == 0) begin
          errs++;
          $display("FAIL sb_empty: MEM/WB result with nothing expected");
        end else begin
          e = sb_q.pop_front();
          chk("RegWriteOut", 32'(RegWriteOut), 32'(e.rw));
          chk("MemtoRegOut", 32'(MemtoRegOut), 32'(e.m2r));
          chk("RAddrOut",    32'(RAddrOut),    32'(e.ra));
          chk("ALUDataOut",  ALUDataOut,       e.alu);
          chk("MemDataOut",  MemDataOut,       e.mdata);
          chk("AddrErr",     32'(AddrErr),     32'(e.aerr));
        end
      end
      if (prev_stall) begin
        chk("bubble_RegWrite", 32'(RegWriteOut), 32'h0);
        chk("bubble_MemtoReg", 32'(MemtoRegOut), 32'h0);
      end
      pending    = op_valid && (Stall === 1'b0);
      prev_stall = (Stall === 1'b1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.MemAck   = 1'b0;
    bus.MemRData = 32'h0;
    clear_inputs();
    nReset = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check_zero("rst0");
    chk("rst0_Stall", 32'(Stall), 32'h0);
    nReset = 1'b1;

    // word load, ack in first BUSY cycle
    run_op(1, 0, 1, 1, 3'b010, 32'h0000_0100, 32'h0, 5'd3, 0, 32'hDEAD_BEEF);
    // signed / unsigned byte at lane 3
    run_op(1, 0, 1, 1, 3'b000, 32'h0000_0103, 32'h0, 5'd4, 0, 32'h8012_3456);
    run_op(1, 0, 1, 1, 3'b100, 32'h0000_0103, 32'h0, 5'd5, 1, 32'h8012_3456);
    // signed half, upper lane
    run_op(1, 0, 1, 1, 3'b001, 32'h0000_0102, 32'h0, 5'd6, 0, 32'h7FFF_0000);
    // half store, three waited BUSY cycles
    run_op(0, 1, 0, 0, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 5'd0, 3, 32'h0);
    // misaligned word load
    run_op(1, 0, 1, 1, 3'b010, 32'h0000_0101, 32'h0, 5'd8, 0, 32'h0);
    // load then non-memory op
    run_op(1, 0, 1, 1, 3'b101, 32'h0000_0302, 32'h0, 5'd9, 2, 32'hF00D_8001);
    run_op(0, 0, 1, 0, 3'b000, 32'h0000_0055, 32'h0, 5'd7, 0, 32'h0);
    // read+write together behaves as a write
    run_op(1, 1, 0, 0, 3'b000, 32'h0000_0401, 32'h0000_00A5, 5'd1, 1, 32'h0);

    // reset while BUSY
    @(posedge Clock); #1;
    RegWriteIn = 1; MemReadIn = 1; MemWriteIn = 0; MemtoRegIn = 1;
    MemfuncIn = 3'b010; AddrIn = 32'h0000_0500; RtDataIn = 0; RAddrIn = 5'd2;
    op_valid = 1'b1;
    bus_q.push_back('{we: 1'b0, addr: 32'h0000_0500, be: 4'hF, wdata: 32'h0,
                      wait_n: 20, rdata: 32'h1111_2222});
    repeat (3) @(negedge Clock);
    #3;
    nReset = 1'b0;
    #1;
    check_zero("rst_busy");
    clear_inputs();
    bus.MemAck = 1'b0;
    bus_q.delete();
    sb_q.delete();
    exp_mdata = 32'h0;
    repeat (2) @(posedge Clock);
    #1;
    nReset = 1'b1;
    run_op(1, 0, 1, 1, 3'b010, 32'h0000_0600, 32'h0, 5'd10, 0, 32'hCAFE_F00D);

    // random ops
    for (int i = 0; i < 60; i++) begin
      run_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
             $urandom, $urandom, 5'($urandom), int'($urandom_range(0, 3)), $urandom);
    end

    @(posedge Clock); #1;
    clear_inputs();
    repeat (3) @(negedge Clock);
    #2;
    chk("sb_drained",  32'(sb_q.size()),  32'h0);
    chk("bus_drained", 32'(bus_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errs + 1, chks + 1);
    $fatal(1, "watchdog");
  end

endmodule
